// File: rtl/reg_bank_ctx.sv
// CPU register file with carry flag, optional write-to-read bypass and a shadow
// context bank that is saved/restored one register per cycle for interrupts.
module reg_bank_ctx #(
  parameter int  DATA_W   = 8,
  parameter int  NUM_REGS = 8,
  parameter bit  BYPASS   = 1'b1,
  localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  ri_sel,
  input  logic [SEL_W-1:0]  rj_sel,
  output logic [DATA_W-1:0] ri_data,
  output logic [DATA_W-1:0] rj_data,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              c_update,
  input  logic              c_in,
  output logic              c_flag,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_REGS - 1);

  state_t            state, state_n;
  logic [SEL_W-1:0]  idx, idx_n;
  logic              done_n;
  logic [DATA_W-1:0] regs   [NUM_REGS];
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic              shadow_c;
  logic              wr_ok;

  // A write to a select beyond the populated depth is silently dropped.
  assign wr_ok = wr_en && (int'(wr_sel) < NUM_REGS);
  assign busy  = (state != IDLE);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      done  <= done_n;
    end
  end

  // NOTE: defaults first so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_n = state;
    idx_n   = idx;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (save_req) begin
          state_n = SAVE;
          idx_n   = '0;
        end else if (restore_req) begin
          state_n = RESTORE;
          idx_n   = '0;
        end
      end
      SAVE, RESTORE: begin
        if (idx == LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          idx_n = idx + SEL_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: both banks are architectural state cleared by reset, so they are
  // built from resettable flops rather than an unreset RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r]   <= '0;
        shadow[r] <= '0;
      end
      c_flag   <= 1'b0;
      shadow_c <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok)    regs[wr_sel] <= wr_data;
          if (c_update) c_flag       <= c_in;
        end
        SAVE: begin
          shadow[idx] <= regs[idx];
          if (idx == LAST) shadow_c <= c_flag;
        end
        RESTORE: begin
          regs[idx] <= shadow[idx];
          if (idx == LAST) c_flag <= shadow_c;
        end
        default: ;
      endcase
    end
  end

  // Bypass only forwards writes that will actually land, and only in IDLE.
  always_comb begin
    ri_data = '0;
    rj_data = '0;
    if (int'(ri_sel) < NUM_REGS) ri_data = regs[ri_sel];
    if (int'(rj_sel) < NUM_REGS) rj_data = regs[rj_sel];
    if (BYPASS && (state == IDLE) && wr_ok) begin
      if (wr_sel == ri_sel) ri_data = wr_data;
      if (wr_sel == rj_sel) rj_data = wr_data;
    end
  end

endmodule

// File: doc/reg_bank_ctx.md
Name: reg_bank_ctx

Overview:
- Parametrised CPU register file: NUM_REGS x DATA_W general registers, two combinational read ports (operands i, j) and one synchronous write port (result k).
- Carry flag register; optional write-to-read bypass.
- Shadow context bank with a sequential save/restore engine, copying one register per cycle, for interrupt entry/exit.
- Sits between the decoder/ALU and the writeback stage of the 8-bit CPU.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 8, number of general registers (2..32).
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value.
- SEL_W (localparam) = max(1, clog2(NUM_REGS)).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, reset: asynchronous, active-high.
- ri_sel, input, SEL_W, first-operand register select.
- rj_sel, input, SEL_W, second-operand register select.
- ri_data, output, DATA_W, first-operand data.
- rj_data, output, DATA_W, second-operand data.
- wr_en, input, 1, result write enable.
- wr_sel, input, SEL_W, result register select.
- wr_data, input, DATA_W, result data.
- c_update, input, 1, load carry flag from c_in.
- c_in, input, 1, carry from ALU.
- c_flag, output, 1, registered carry flag.
- save_req, input, 1, request copy of main bank + carry into shadow.
- restore_req, input, 1, request copy of shadow into main bank + carry.
- busy, output, 1, save/restore engine active.
- done, output, 1, one-cycle pulse at engine completion.

Behaviour:
- Reset (any time, including mid-save/restore): all main registers, all shadow registers, c_flag, busy, done = 0; FSM -> IDLE; ri_data/rj_data = 0 (stored values are zero).
- Reads: combinational from the main array, zero latency.
- Read select >= NUM_REGS (non-power-of-2 depth): read data = 0.
- Bypass (BYPASS=1 and FSM in IDLE): if wr_en and wr_sel == ri_sel, ri_data = wr_data; same rule for rj_sel/rj_data.
- Writes: reg[wr_sel] <= wr_data at posedge when wr_en, FSM in IDLE, and wr_sel < NUM_REGS; otherwise the write is dropped.
- Carry: c_flag <= c_in at posedge when c_update and FSM in IDLE; otherwise c_flag holds (except during RESTORE).
- Engine FSM states: IDLE, SAVE, RESTORE; internal index idx, SEL_W bits.
- IDLE, on save_req: next state SAVE, idx <= 0. Save_req has priority over a simultaneous restore_req.
- IDLE, on restore_req (save_req low): next state RESTORE, idx <= 0.
- Register writes and c_update presented in the request-accept cycle are performed, so a save captures them.
- SAVE cycle: shadow[idx] <= reg[idx]. On idx == NUM_REGS-1, also shadow_c <= c_flag, then next state IDLE and done <= 1; otherwise idx <= idx+1.
- RESTORE cycle: reg[idx] <= shadow[idx]. On idx == NUM_REGS-1, also c_flag <= shadow_c, then next state IDLE and done <= 1; otherwise idx <= idx+1.
- busy = 1 exactly when state != IDLE (registered state decode). Timing: request accepted at edge E0; busy high for the NUM_REGS cycles after E0; done high for the single cycle after that, with busy low.
- Requests while busy: ignored, not queued.
- wr_en / c_update while busy: dropped.
- Reads while busy: return the current main array with no bypass; during RESTORE, registers not yet restored show their old values.
- done defaults to 0 every cycle in which it is not set by the last copy.
- Restore with no prior save restores zeros (the post-reset shadow contents).

Test Plan:
- After reset: write R3=0x5A (wr_en=1, wr_sel=3) -> next cycle ri_sel=3 gives ri_data=0x5A. With BYPASS=1, the same-cycle read of R3 during the write shows 0x5A; BYPASS=0 shows 0x00.
- Write R0..R7 = 0x10..0x17, c_update=1 with c_in=1; pulse save_req -> busy high 8 cycles, then done=1 for 1 cycle. Overwrite all registers with 0xFF and c_in=0; pulse restore_req -> after done, R0..R7 read 0x10..0x17 and c_flag=1.
- save_req and restore_req asserted in the same IDLE cycle -> SAVE runs (shadow updated, main unchanged). restore_req pulsed mid-SAVE -> ignored, done pulses once.
- wr_en=1 to R2 with 0xAA during busy -> R2 unchanged after completion. Write accepted in the same cycle as save_req -> shadow[2] holds the new value.
- rst asserted at the 4th RESTORE cycle -> busy, done, c_flag and all registers read 0 immediately; a subsequent restore yields zeros.
- NUM_REGS=5 build: wr_sel=6 write is dropped, ri_sel=6 reads 0x00, and save/restore completes in 5 busy cycles.
